// File: rtl/mc_control.sv
// mc_control: multi-cycle main control FSM for the MIPS-subset CPU.
// One micro-step per clock; stalls in MEM_RD / MEM_WR until mem_ready_i.
// State codes on state_o: IDLE=0 FETCH=1 DECODE=2 ADDR=3 MEM_RD=4 WB_MEM=5
// MEM_WR=6 EXEC_R=7 WB_R=8 EXEC_I=9 WB_I=10 BRANCH=11 JUMP=12.
// Moore outputs are registered, decoded from the next state so that they
// line up with the state register. pc_we_o in BRANCH and illegal_o are
// the only outputs that depend on inputs combinationally.
module mc_control (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_we_o,
    output logic        ir_we_o,
    output logic        reg_we_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_ctrl_o,
    output logic [1:0]  pc_src_o,
    output logic        illegal_o,
    output logic [3:0]  state_o,
    output logic [31:0] retired_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_WB_MEM = 4'd5,
        S_MEM_WR = 4'd6,
        S_EXEC_R = 4'd7,
        S_WB_R   = 4'd8,
        S_EXEC_I = 4'd9,
        S_WB_I   = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Returns {legal, alu_ctrl} for an R-type funct field.
    function automatic logic [3:0] funct_decode(input logic [5:0] funct);
        logic [3:0] res;
        case (funct)
            6'b100000: res = {1'b1, ALU_ADD};
            6'b100010: res = {1'b1, ALU_SUB};
            6'b100100: res = {1'b1, ALU_AND};
            6'b100101: res = {1'b1, ALU_OR};
            6'b101010: res = {1'b1, ALU_SLT};
            default:   res = {1'b0, ALU_AND};
        endcase
        return res;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_boundary;
    logic        w_final;
    logic        w_illegal;
    logic [3:0]  w_funct_dec;

    logic        r_pc_we;
    logic        r_ir_we;
    logic        r_reg_we;
    logic        r_reg_dst;
    logic        r_mem_to_reg;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_alu_src_a;
    logic [1:0]  r_alu_src_b;
    logic [2:0]  r_alu_ctrl;
    logic [1:0]  r_pc_src;
    logic [31:0] r_retired;

    assign w_funct_dec = funct_decode(funct_i);
    assign w_boundary  = start_i ? S_FETCH : S_IDLE;

    // Next-state, final-cycle and illegal-instruction decode.
    always_comb begin
        w_state_next = r_state;
        w_final      = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_IDLE:   if (start_i) w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: w_state_next = S_ADDR;
                    OP_ADDI:      w_state_next = S_EXEC_I;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_J:         w_state_next = S_JUMP;
                    OP_RTYPE: begin
                        if (w_funct_dec[3]) begin
                            w_state_next = S_EXEC_R;
                        end else begin
                            w_illegal    = 1'b1;
                            w_state_next = w_boundary;
                        end
                    end
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = w_boundary;
                    end
                endcase
            end
            S_ADDR:   w_state_next = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready_i) w_state_next = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    w_final      = 1'b1;
                    w_state_next = w_boundary;
                end
            end
            S_EXEC_R: w_state_next = S_WB_R;
            S_EXEC_I: w_state_next = S_WB_I;
            S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
                w_final      = 1'b1;
                w_state_next = w_boundary;
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State register, registered Moore outputs and retired counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_pc_we      <= 1'b0;
            r_ir_we      <= 1'b0;
            r_reg_we     <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 2'b00;
            r_alu_ctrl   <= 3'b000;
            r_pc_src     <= 2'b00;
            r_retired    <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_pc_we      <= 1'b0;
            r_ir_we      <= 1'b0;
            r_reg_we     <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= 2'b00;
            r_alu_ctrl   <= 3'b000;
            r_pc_src     <= 2'b00;
            if (w_final) begin
                r_retired <= r_retired + 32'd1;
            end
            case (w_state_next)
                S_FETCH: begin
                    r_ir_we     <= 1'b1;
                    r_pc_we     <= 1'b1;
                    r_alu_src_b <= 2'b01;
                    r_alu_ctrl  <= ALU_ADD;
                end
                S_DECODE: begin
                    r_alu_src_b <= 2'b11;
                    r_alu_ctrl  <= ALU_ADD;
                end
                S_ADDR, S_EXEC_I: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'b10;
                    r_alu_ctrl  <= ALU_ADD;
                end
                S_MEM_RD: r_mem_rd <= 1'b1;
                S_WB_MEM: begin
                    r_reg_we     <= 1'b1;
                    r_mem_to_reg <= 1'b1;
                end
                S_MEM_WR: r_mem_wr <= 1'b1;
                // IR is stable from DECODE onward, so funct here is the
                // funct of the instruction being executed.
                S_EXEC_R: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_ctrl  <= w_funct_dec[2:0];
                end
                S_WB_R: begin
                    r_reg_we  <= 1'b1;
                    r_reg_dst <= 1'b1;
                end
                S_WB_I:   r_reg_we <= 1'b1;
                S_BRANCH: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_ctrl  <= ALU_SUB;
                    r_pc_src    <= 2'b01;
                end
                S_JUMP: begin
                    r_pc_we  <= 1'b1;
                    r_pc_src <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    // BRANCH writes the PC only when the compare found equality.
    assign pc_we_o      = r_pc_we | ((r_state == S_BRANCH) & zero_i);
    assign ir_we_o      = r_ir_we;
    assign reg_we_o     = r_reg_we;
    assign reg_dst_o    = r_reg_dst;
    assign mem_to_reg_o = r_mem_to_reg;
    assign mem_rd_o     = r_mem_rd;
    assign mem_wr_o     = r_mem_wr;
    assign alu_src_a_o  = r_alu_src_a;
    assign alu_src_b_o  = r_alu_src_b;
    assign alu_ctrl_o   = r_alu_ctrl;
    assign pc_src_o     = r_pc_src;
    assign illegal_o    = w_illegal;
    assign state_o      = r_state;
    assign retired_o    = r_retired;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle sequencer for the single-issue MIPS-subset CPU. It holds the main control FSM, decodes opcode/funct from the instruction register, and drives the PC, IR, register-file, ALU-mux and data-memory enables, one micro-step per clock. It sits inside `CPU` beside the PC, register file and memories, and stalls on a data-memory ready handshake. Instruction memory is combinational and always ready.

## Interface
- No parameters.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  run enable; sampled at instruction boundaries.
- `opcode_i`  in  6  IR[31:26].
- `funct_i`  in  6  IR[5:0].
- `zero_i`  in  1  ALU zero flag.
- `mem_ready_i`  in  1  data memory completes the current access this cycle.
- `pc_we_o`  out  1  PC write enable.
- `ir_we_o`  out  1  IR write enable.
- `reg_we_o`  out  1  register-file write enable.
- `reg_dst_o`  out  1  write register select: 0 = rt, 1 = rd.
- `mem_to_reg_o`  out  1  write data select: 0 = ALUOut, 1 = MDR.
- `mem_rd_o`  out  1  data memory read request.
- `mem_wr_o`  out  1  data memory write request.
- `alu_src_a_o`  out  1  ALU A: 0 = PC, 1 = rs.
- `alu_src_b_o`  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_ctrl_o`  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- `pc_src_o`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 2'b00}.
- `illegal_o`  out  1  one-cycle pulse on an unsupported instruction.
- `state_o`  out  4  current state code, for debug.
- `retired_o`  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, ADDR, MEM_RD, WB_MEM, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP. The state encoding is free, but `state_o` must be distinct per state.
- Every output defaults to 0 in every state unless listed below.
- IDLE: all outputs 0. Go to FETCH when `start_i`=1.
- FETCH: `ir_we`=1, `pc_we`=1, A=0, B=01, add, `pc_src`=00. Go to DECODE.
- DECODE: A=0, B=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 → ADDR.
  - 000000 with a legal funct → EXEC_R.
  - 001000 → EXEC_I.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - Anything else, or opcode 000000 with an illegal funct → `illegal_o`=1 in this DECODE cycle; go to the boundary.
- Legal funct mapping: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- ADDR: A=1, B=10, add. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_rd`=1. Stay while `mem_ready_i`=0. When it is 1, go to WB_MEM.
- WB_MEM: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1.
- MEM_WR: `mem_wr`=1. Stay while `mem_ready_i`=0. When it is 1, the instruction is final.
- EXEC_R: A=1, B=00, `alu_ctrl` from funct. Go to WB_R.
- WB_R: `reg_we`=1, `reg_dst`=1.
- EXEC_I: A=1, B=10, add. Go to WB_I.
- WB_I: `reg_we`=1, `reg_dst`=0.
- BRANCH: A=1, B=00, sub, `pc_src`=01, `pc_we`=`zero_i` (Mealy).
- JUMP: `pc_src`=10, `pc_we`=1.
- Final cycles: WB_MEM, WB_R, WB_I, BRANCH, JUMP, and MEM_WR with ready=1.
  - In a final cycle, `retired_o` increments by 1 (wraps at 2^32−1 → 0).
  - The instruction boundary follows every final cycle and every illegal DECODE.
- Boundary: next state is FETCH if `start_i`=1, otherwise IDLE. An illegal instruction is not counted.
- Dropping `start_i` mid-instruction never aborts that instruction.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `retired_o`=0, all outputs 0.
- Release of reset is synchronous to the next edge.
- Latency from FETCH entry to the boundary, with zero memory wait:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle with `mem_ready_i`=0 in MEM_RD/MEM_WR adds exactly 1 cycle.
- `mem_rd_o`/`mem_wr_o` are held constant through a stall.
- `mem_ready_i` is ignored outside MEM_RD/MEM_WR.
- All outputs are Moore decoded from state, except `pc_we_o` in BRANCH and `illegal_o`, which depend on inputs combinationally.
- `retired_o` is registered; it updates on the edge leaving the final cycle.

## Test plan
- Reset mid-lw during a MEM_RD stall → state IDLE at once, all outputs 0, `retired_o`=0. After release with `start_i`=1, FETCH begins on the next edge.
- add (opcode 0, funct 100000) with `start_i`=1 → states FETCH, DECODE, EXEC_R, WB_R, FETCH. `alu_ctrl`=010 in EXEC_R, `reg_we`=`reg_dst`=1 in WB_R, `retired_o` 0→1.
- lw with `mem_ready_i` low for 3 cycles → MEM_RD lasts 4 cycles with `mem_rd_o`=1 throughout, total 8 cycles, WB_MEM has `mem_to_reg`=1.
- beq with `zero_i`=1, then with `zero_i`=0 → BRANCH `pc_we_o`=1 with `pc_src`=01 in the first case, `pc_we_o`=0 in the second. Both take 3 cycles.
- Opcode 111111, then opcode 0 with funct 000001 → one `illegal_o` pulse each in DECODE, back to FETCH after 2 cycles, `retired_o` unchanged.
- `start_i` dropped during EXEC_I of addi → WB_I completes (`reg_we`=1, count +1), then IDLE. Raising `start_i` resumes at FETCH.
